score_counter: RTL and testbench
================================

Name: score_counter

Overview:
- Parametrised successor to the single-bit score flag. Watches one probe pixel of the green (pipe) plane of the ROWS x COLS LED frame.
- Counts each pipe pass once, as a multi-digit BCD score, under a small game-state FSM (IDLE / PLAYING / OVER).
- Feeds the score display and game-over logic.

Parameters:
- ROWS, 16, rows in the green frame (first index of green)
- COLS, 16, columns in the green frame (second index)
- PROBE_ROW, 15, row index of the probe pixel, 0..ROWS-1
- PROBE_COL, 14, column index of the probe pixel, 0..COLS-1
- DIGITS, 2, BCD digits in score and high score, 1..4
- HOLDOFF, 4, cycles after a counted point during which new rises are ignored; 0 disables holdoff

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- green  in  [ROWS-1:0][COLS-1:0]  green (pipe) pixel plane
- start  in  1  start / restart game, level-sampled
- collide  in  1  bird collision, level-sampled
- state  out  2  0=IDLE, 1=PLAYING, 2=OVER (3 never driven)
- point  out  1  one-cycle pulse per counted point
- score_bcd  out  4*DIGITS  current score, packed BCD, digit 0 in [3:0]
- hiscore_bcd  out  4*DIGITS  best score since rst (see Optional Feature)
- new_record  out  1  last finished game set a new high score

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high. All registers update on posedge clk only.
- Reset values (rst high at an edge), including mid-game reset: state=IDLE, point=0, score_bcd=0, hiscore_bcd=0, new_record=0, probe_q=0, holdoff_cnt=0.
- Probe detection:
  - probe = green[PROBE_ROW][PROBE_COL].
  - probe_q registers probe every cycle, in every state.
  - rise = probe & ~probe_q. A pixel held high for N cycles gives exactly one rise.
- FSM:
  - IDLE: start=1 -> PLAYING; score_bcd cleared to 0; new_record cleared.
  - PLAYING: collide=1 -> OVER, with priority over any rise in that cycle (no point counted). start is ignored.
  - OVER: score frozen. start=1 -> PLAYING; score cleared; new_record cleared. collide is ignored.
- Counting, in PLAYING only, when rise=1, collide=0 and holdoff_cnt=0:
  - At the same edge: score_bcd increments as decimal with per-digit carry (9 -> 0, carry up), point<=1, holdoff_cnt<=HOLDOFF.
  - Latency: point and the new score are visible one cycle after the edge that samples the rise.
- Pulse and holdoff:
  - point is high for exactly one cycle.
  - holdoff_cnt decrements by 1 per cycle while nonzero, in any state.
- Saturation: at all-9s (99 for DIGITS=2) the score holds; point still pulses for a qualifying rise.
- Outside PLAYING: rises are tracked by probe_q but never counted. A pixel already high when PLAYING is entered does not score until it falls and rises again.
- start and collide in the same cycle:
  - IDLE/OVER: start wins -> PLAYING.
  - PLAYING: collide wins -> OVER.
- Width: holdoff_cnt is wide enough for HOLDOFF (minimum 1 bit). Indices outside range are an elaboration error.

Optional Feature:
- Macro: SCORE_HISCORE_EN.
- Defined:
  - On the PLAYING->OVER edge, compare score_bcd to hiscore_bcd as unsigned BCD (digit-wise, most significant first).
  - If score_bcd is strictly greater: hiscore_bcd<=score_bcd and new_record<=1.
  - new_record holds until the next start or rst.
  - hiscore_bcd is cleared only by rst.
- Not defined: hiscore_bcd and new_record are tied to 0 and no compare logic is built; all other behaviour is identical.

Test Plan:
- Count once per pass: rst; start; probe high for 3 cycles -> one point pulse, one cycle after the rise; score_bcd=8'h01; state=1.
- Decimal carry: 10 separated rises -> score_bcd=8'h10. 100 rises -> score_bcd=8'h99 (saturated), 100 point pulses.
- Holdoff: HOLDOFF=4; rises 2 cycles apart -> 1 point. Rises 6 cycles apart -> 2 points.
- Collide priority and restart: at score 03, rise and collide in the same cycle -> state=2, score 8'h03, no point. Then start -> state=1, score 0. A rise while in OVER -> no point.
- High score (SCORE_HISCORE_EN): game 1 scores 5, collide -> hiscore 8'h05, new_record=1. Game 2 scores 3, collide -> hiscore 8'h05, new_record=0. Without the macro -> hiscore 0, new_record 0.
- Reset mid-game: at score 07 with holdoff active, assert rst for 1 cycle -> all outputs 0, state=0. A probe held high across the reset does not score after the next start.

Source files
------------

// File: rtl/score_counter_if.sv
// rtl/score_counter_if.sv - frame, game-control and score signals between score_counter and its user
interface score_counter_if #(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int DIGITS = 2
);
    logic [ROWS-1:0][COLS-1:0] green;
    logic                      start;
    logic                      collide;
    logic [1:0]                state;
    logic                      point;
    logic [4*DIGITS-1:0]       score_bcd;
    logic [4*DIGITS-1:0]       hiscore_bcd;
    logic                      new_record;

    modport master (
        output green, start, collide,
        input  state, point, score_bcd, hiscore_bcd, new_record
    );

    modport slave (
        input  green, start, collide,
        output state, point, score_bcd, hiscore_bcd, new_record
    );
endinterface

// File: rtl/score_counter.sv
// rtl/score_counter.sv - BCD pipe-pass score counter with IDLE/PLAYING/OVER game FSM
// High-score tracking is built only when SCORE_HISCORE_EN is defined.
module score_counter #(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int PROBE_ROW = 15,
    parameter int PROBE_COL = 14,
    parameter int DIGITS    = 2,
    parameter int HOLDOFF   = 4
) (
    input logic           clk,
    input logic           rst,
    score_counter_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_OVER    = 2'd2;

    localparam int              HW        = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0]   HOLDOFF_V = HW'(HOLDOFF);
    localparam int              SW        = 4 * DIGITS;

    generate
        if (PROBE_ROW < 0 || PROBE_ROW >= ROWS || PROBE_COL < 0 || PROBE_COL >= COLS) begin : g_bad_probe
            $error("score_counter: probe pixel outside the green frame");
        end
        if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
            $error("score_counter: DIGITS must be 1..4");
        end
        if (HOLDOFF < 0) begin : g_bad_holdoff
            $error("score_counter: HOLDOFF must be non-negative");
        end
    endgenerate

    function automatic logic bcd_all_nines(input logic [SW-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) r = 1'b0;
        end
        return r;
    endfunction

    // Ripple a decimal +1 through the digits; 9 wraps to 0 and carries.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [1:0]    state;
    logic          point;
    logic [SW-1:0] score_bcd;
    logic          probe;
    logic          probe_q;
    logic          rise;
    logic [HW-1:0] holdoff_cnt;
    logic          count_en;
    logic          game_start;
    logic          game_end;
    logic          unused_green;

    assign probe        = bus.green[PROBE_ROW][PROBE_COL];
    assign unused_green = ^bus.green;
    assign rise         = probe & ~probe_q;

    assign count_en   = (state == ST_PLAYING) && rise && !bus.collide && (holdoff_cnt == '0);
    assign game_start = ((state == ST_IDLE) || (state == ST_OVER)) && bus.start;
    assign game_end   = (state == ST_PLAYING) && bus.collide;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            point       <= 1'b0;
            score_bcd   <= '0;
            probe_q     <= 1'b0;
            holdoff_cnt <= '0;
        end else begin
            probe_q <= probe;
            point   <= count_en;

            if (count_en) begin
                holdoff_cnt <= HOLDOFF_V;
            end else if (holdoff_cnt != '0) begin
                holdoff_cnt <= holdoff_cnt - HW'(1);
            end

            case (state)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        state     <= ST_PLAYING;
                        score_bcd <= '0;
                    end
                end
                ST_PLAYING: begin
                    if (bus.collide) begin
                        state <= ST_OVER;
                    end else if (count_en && !bcd_all_nines(score_bcd)) begin
                        score_bcd <= bcd_inc(score_bcd);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.state     = state;
    assign bus.point     = point;
    assign bus.score_bcd = score_bcd;

`ifdef SCORE_HISCORE_EN
    // Most significant differing digit decides; equal scores are not a record.
    function automatic logic bcd_gt(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                gt      = (a[4*i +: 4] > b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

    logic [SW-1:0] hiscore_bcd;
    logic          new_record;

    always_ff @(posedge clk) begin
        if (rst) begin
            hiscore_bcd <= '0;
            new_record  <= 1'b0;
        end else if (game_start) begin
            new_record <= 1'b0;
        end else if (game_end && bcd_gt(score_bcd, hiscore_bcd)) begin
            hiscore_bcd <= score_bcd;
            new_record  <= 1'b1;
        end
    end

    assign bus.hiscore_bcd = hiscore_bcd;
    assign bus.new_record  = new_record;
`else
    logic unused_game_edges;
    assign unused_game_edges = game_start ^ game_end;
    assign bus.hiscore_bcd   = '0;
    assign bus.new_record    = 1'b0;
`endif

endmodule

// File: tb/tb_score_counter.sv
// tb/tb_score_counter.sv - scoreboard bench for score_counter; expectations follow SCORE_HISCORE_EN
module tb_score_counter;
    localparam int ROWS = 16, COLS = 16, PR = 15, PC = 14, DIGITS = 2, HOLDOFF = 4;
`ifdef SCORE_HISCORE_EN
    localparam bit HI = 1'b1;
`else
    localparam bit HI = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    score_counter_if #(.ROWS(ROWS), .COLS(COLS), .DIGITS(DIGITS)) bus ();

    score_counter #(
        .ROWS(ROWS), .COLS(COLS), .PROBE_ROW(PR), .PROBE_COL(PC),
        .DIGITS(DIGITS), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         n_points = 0;
    int         m_score  = 0;
    int         base;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    // Monitor: every point pulse must match the oldest expected score.
    always @(negedge clk) begin
        if (bus.point === 1'b1) begin
            n_points++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_point: got point with score %0h expected no point", bus.score_bcd);
            end else begin
                mon_e = exp_q.pop_front();
                chk("point_score", {24'd0, bus.score_bcd}, {24'd0, mon_e});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_probe(input logic v);
        bus.green[PR][PC] = v;
    endtask

    task automatic expect_point();
        m_score = (m_score < 99) ? m_score + 1 : 99;
        exp_q.push_back(to_bcd(m_score));
    endtask

    task automatic rise(input int gap, input bit counts);
        set_probe(1'b1);
        if (counts) expect_point();
        tick(1);
        set_probe(1'b0);
        tick(gap - 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        m_score = 0;
    endtask

    task automatic do_collide();
        bus.collide = 1'b1;
        tick(1);
        bus.collide = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_state"}, bus.state, 0);
        chk({tag, "_score"}, bus.score_bcd, 0);
        chk({tag, "_point"}, bus.point, 0);
        chk({tag, "_hiscore"}, bus.hiscore_bcd, 0);
        chk({tag, "_new_record"}, bus.new_record, 0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.green   = '0;
        bus.start   = 1'b0;
        bus.collide = 1'b0;
        tick(2);
        chk_zero_outputs("reset");
        rst = 1'b0;
        tick(1);

        // Single pass held high for 3 cycles
        do_start();
        chk("start_state", bus.state, 1);
        chk("start_score", bus.score_bcd, 0);
        base = n_points;
        set_probe(1'b1);
        expect_point();
        tick(1);
        chk("latency_point", bus.point, 1);
        tick(1);
        chk("point_one_cycle", bus.point, 0);
        tick(1);
        set_probe(1'b0);
        tick(5);
        chk("pass_score", bus.score_bcd, 8'h01);
        chk("pass_state", bus.state, 1);
        chk("pass_points", n_points - base, 1);

        // Neighbouring pixels must never score
        for (int k = 0; k < 3; k++) begin
            bus.green[PR-1][PC] = 1'b1; bus.green[PR][PC+1] = 1'b1; bus.green[PR][PC-1] = 1'b1;
            tick(1);
            bus.green[PR-1][PC] = 1'b0; bus.green[PR][PC+1] = 1'b0; bus.green[PR][PC-1] = 1'b0;
            tick(5);
        end
        chk("neighbour_score", bus.score_bcd, 8'h01);

        // Decimal carry and saturation
        do_collide();
        chk("over_state", bus.state, 2);
        do_start();
        chk("restart_score", bus.score_bcd, 0);
        base = n_points;
        repeat (10) rise(6, 1'b1);
        drain();
        chk("carry_10", bus.score_bcd, 8'h10);
        repeat (90) rise(6, 1'b1);
        drain();
        chk("reach_99", bus.score_bcd, 8'h99);
        repeat (5) rise(6, 1'b1);
        drain();
        chk("saturate_99", bus.score_bcd, 8'h99);
        chk("saturate_points", n_points - base, 105);

        // Holdoff: 2 apart -> one point, 6 apart -> two points
        do_collide();
        do_start();
        tick(6);
        rise(2, 1'b1);
        rise(6, 1'b0);
        rise(6, 1'b1);
        rise(6, 1'b1);
        drain();
        chk("holdoff_score", bus.score_bcd, 8'h03);

        // Collide wins over a same-cycle rise
        tick(6);
        set_probe(1'b1);
        bus.collide = 1'b1;
        tick(1);
        bus.collide = 1'b0;
        chk("collide_point", bus.point, 0);
        chk("collide_state", bus.state, 2);
        chk("collide_score", bus.score_bcd, 8'h03);
        set_probe(1'b0);
        tick(2);
        rise(6, 1'b0);
        chk("over_rise_score", bus.score_bcd, 8'h03);
        bus.start = 1'b1;
        bus.collide = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.collide = 1'b0;
        m_score = 0;
        chk("start_wins_state", bus.state, 1);
        chk("start_wins_score", bus.score_bcd, 0);

        // High score across two games
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        do_start();
        repeat (5) rise(6, 1'b1);
        drain();
        do_collide();
        chk("game1_hiscore", bus.hiscore_bcd, HI ? 8'h05 : 8'h00);
        chk("game1_record", bus.new_record, HI ? 1 : 0);
        do_start();
        chk("game2_record_clr", bus.new_record, 0);
        repeat (3) rise(6, 1'b1);
        drain();
        do_collide();
        chk("game2_hiscore", bus.hiscore_bcd, HI ? 8'h05 : 8'h00);
        chk("game2_record", bus.new_record, 0);

        // Reset mid-game with holdoff running and probe held high
        do_start();
        repeat (6) rise(6, 1'b1);
        set_probe(1'b1);
        expect_point();
        tick(1);
        chk("pre_reset_score", bus.score_bcd, 8'h07);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_zero_outputs("midreset");
        m_score = 0;
        do_start();
        tick(8);
        chk("held_probe_score", bus.score_bcd, 0);
        set_probe(1'b0);
        tick(1);
        rise(6, 1'b1);
        drain();
        chk("after_reset_score", bus.score_bcd, 8'h01);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
